// File: rtl/cos_job_dispatcher.sv
// cos_job_dispatcher: buffers (x, y) jobs in a small FIFO and issues them one at a time to the cos core.
// Latency 1 + START_CYCLES + core latency + 1 per job; in_ready low while full, out_valid held until out_ready.
module cos_job_dispatcher #(
  parameter int XW           = 16,
  parameter int YW           = 8,
  parameter int RW           = 16,
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XW-1:0]            in_x,
  input  logic [YW-1:0]            in_y,
  output logic [XW-1:0]            core_x,
  output logic [YW-1:0]            core_y,
  output logic                     core_start,
  input  logic                     core_ready,
  input  logic [RW-1:0]            core_cos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_cos,
  output logic                     out_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    FULL_CNT   = DEPTH[AW:0];
  localparam logic [WDW-1:0] START_LAST = WDW'(START_CYCLES - 1);
  localparam logic [WDW-1:0] TO_LAST    = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t           state_q;
  logic [XW+YW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [XW-1:0]    head_x, core_x_q;
  logic [YW-1:0]    head_y, core_y_q;
  logic             core_start_q, out_valid_q, out_timeout_q, busy_q;
  logic [RW-1:0]    out_cos_q, edge_cos_q;
  logic [WDW-1:0]   wdog_q;
  logic             rdy_prev_q, edge_seen_q;
  logic             fifo_push, fifo_pop, rdy_rise;

  assign in_ready  = (count_q != FULL_CNT);
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == S_IDLE) && (count_q != '0);
  assign rdy_rise  = core_ready && !rdy_prev_q;
  assign {head_x, head_y} = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (fifo_push && !fifo_pop)
      count_d = count_q + 1'b1;
    else if (fifo_pop && !fifo_push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fifo_push)
      mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      core_x_q      <= '0;
      core_y_q      <= '0;
      core_start_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_cos_q     <= '0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      wdog_q        <= '0;
      rdy_prev_q    <= 1'b0;
      edge_seen_q   <= 1'b0;
      edge_cos_q    <= '0;
    end else begin
      rdy_prev_q <= core_ready;
      count_q    <= count_d;
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            core_x_q     <= head_x;
            core_y_q     <= head_y;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            wdog_q       <= '0;
            edge_seen_q  <= 1'b0;
            state_q      <= S_START;
          end
        end
        S_START: begin
          wdog_q <= wdog_q + 1'b1;
          // A fast core may finish while start is still asserted; keep the first result.
          if (rdy_rise && !edge_seen_q) begin
            edge_seen_q <= 1'b1;
            edge_cos_q  <= core_cos;
          end
          if (wdog_q == START_LAST) begin
            core_start_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          if (edge_seen_q || rdy_rise) begin
            out_cos_q     <= edge_seen_q ? edge_cos_q : core_cos;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUT;
          end else if (wdog_q == TO_LAST) begin
            out_cos_q     <= '0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_x      = core_x_q;
  assign core_y      = core_y_q;
  assign core_start  = core_start_q;
  assign out_valid   = out_valid_q;
  assign out_cos     = out_cos_q;
  assign out_timeout = out_timeout_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_cos_job_dispatcher.sv
// Bench for cos_job_dispatcher: behavioural core responder, handshake monitor and per-scenario checks.
module tb_cos_job_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, core_start, out_valid, out_ready, out_timeout, busy;
  logic [15:0] in_x, core_x, out_cos;
  logic [7:0]  in_y, core_y;
  logic        core_ready = 1'b1;
  logic [15:0] core_cos = 16'h0000;
  logic [2:0]  fifo_count;

  logic t_in_valid, t_in_ready, t_core_start, t_out_valid, t_out_ready, t_out_timeout, t_busy;
  logic [15:0] t_in_x, t_core_x, t_out_cos;
  logic [7:0]  t_in_y, t_core_y;
  logic        t_core_ready = 1'b1;
  logic [15:0] t_core_cos = 16'h0000;
  logic [2:0]  t_fifo_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cos_job_dispatcher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .core_x(core_x), .core_y(core_y), .core_start(core_start), .core_ready(core_ready),
    .core_cos(core_cos), .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos),
    .out_timeout(out_timeout), .busy(busy), .fifo_count(fifo_count)
  );

  cos_job_dispatcher #(.TIMEOUT(50)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_x(t_in_x), .in_y(t_in_y),
    .core_x(t_core_x), .core_y(t_core_y), .core_start(t_core_start), .core_ready(t_core_ready),
    .core_cos(t_core_cos), .out_valid(t_out_valid), .out_ready(t_out_ready), .out_cos(t_out_cos),
    .out_timeout(t_out_timeout), .busy(t_busy), .fifo_count(t_fifo_count)
  );

  function automatic logic [15:0] cos_ref(input logic [15:0] x, input logic [7:0] y);
    if (x == 16'h00F5 && y == 8'h05) return 16'h0094;
    if (x == 16'h024C && y == 8'h73) return 16'hFF86;
    return (x ^ {y, 8'hA5}) + 16'h0101;
  endfunction

  // Core responder: mode 0 drops ready on start and raises it with the result after core_lat cycles
  // (core_lat 0 picks a random latency); mode 2 holds ready low. It deliberately ignores rst.
  int core_mode = 0;
  int core_lat = 10;
  int cm_cnt = 0;
  logic cm_busy = 1'b0;
  logic [15:0] cm_x = 16'h0;
  logic [7:0]  cm_y = 8'h0;
  always @(negedge clk) begin
    if (core_mode == 2) begin
      core_ready = 1'b0;
      cm_busy = 1'b0;
    end else if (cm_busy) begin
      cm_cnt--;
      if (cm_cnt <= 0) begin
        core_cos = cos_ref(cm_x, cm_y);
        core_ready = 1'b1;
        cm_busy = 1'b0;
      end
    end else if (core_start) begin
      cm_busy = 1'b1;
      core_ready = 1'b0;
      core_cos = 16'hDEAD;
      cm_x = core_x;
      cm_y = core_y;
      cm_cnt = (core_lat == 0) ? int'($urandom_range(3, 20)) : core_lat;
    end else begin
      core_ready = 1'b1;
    end
  end

  // Monitor: records handshakes, start pulses and operand stability for the scenario tasks.
  int cyc = 0;
  int run = 0;
  int stab_viol = 0;
  logic clr_req = 1'b0;
  logic prev_start = 1'b0, prev_busy = 1'b0;
  logic [15:0] hold_x = 16'h0;
  logic [7:0]  hold_y = 8'h0;
  int obs_cyc[$], start_cyc[$], runlen[$];
  logic [15:0] obs_cos[$], start_x[$];
  logic [7:0]  start_y[$];
  logic        obs_to[$];
  always @(negedge clk) begin
    cyc++;
    if (clr_req) begin
      obs_cyc.delete(); start_cyc.delete(); runlen.delete();
      obs_cos.delete(); start_x.delete(); start_y.delete(); obs_to.delete();
      stab_viol = 0;
    end
    if (rst) begin
      run = 0;
    end else begin
      if (out_valid && out_ready) begin
        obs_cos.push_back(out_cos); obs_to.push_back(out_timeout); obs_cyc.push_back(cyc);
      end
      if (core_start && !prev_start) begin
        start_cyc.push_back(cyc); start_x.push_back(core_x); start_y.push_back(core_y);
      end
      if (core_start) run++;
      else if (prev_start) begin runlen.push_back(run); run = 0; end
      if (busy && prev_busy && (core_x !== hold_x || core_y !== hold_y)) stab_viol++;
    end
    prev_start = core_start;
    prev_busy = busy;
    hold_x = core_x;
    hold_y = core_y;
  end

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_job(input logic [15:0] x, input logic [7:0] y);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; in_x = x; in_y = y;
    while (!acc && n < 2000) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (!acc) begin miscompares++; $display("FAIL push_accept got no in_ready in %0d cycles, want acceptance", n); end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {fifo_count, in_ready, busy, out_valid, core_start, out_timeout};
    vectors++;
    if (got !== 8'b000_10000) begin miscompares++; $display("FAIL reset_ctrl got %b want 00010000", got); end
    vectors++;
    if ({core_x, core_y, out_cos} !== 40'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", {core_x, core_y, out_cos}); end
    got = {t_fifo_count, t_in_ready, t_busy, t_out_valid, t_core_start, t_out_timeout};
    vectors++;
    if (got !== 8'b000_10000 || t_out_cos !== 16'h0) begin miscompares++; $display("FAIL reset_to_inst got %b/%h want 00010000/0000", got, t_out_cos); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, core_start, out_valid, fifo_count} !== 6'd0) begin miscompares++; $display("FAIL reset_release got %b want 000000", {busy, core_start, out_valid, fifo_count}); end
  endtask

  task automatic test_single();
    int n;
    clear_mon();
    core_mode = 0; core_lat = 80; out_ready = 1'b1;
    push_job(16'h00F5, 8'h05);
    n = 0;
    while (obs_cos.size() < 1 && n < 300) begin @(posedge clk); #1; n++; end
    vectors++;
    if (obs_cos.size() != 1 || start_cyc.size() != 1 || runlen.size() != 1) begin
      miscompares++; $display("FAIL single_count got %0d results %0d starts, want 1 and 1", obs_cos.size(), start_cyc.size());
    end else begin
      vectors++;
      if (obs_cos[0] !== 16'h0094 || obs_to[0] !== 1'b0) begin miscompares++; $display("FAIL single_result got %h/%b want 0094/0", obs_cos[0], obs_to[0]); end
      vectors++;
      if (runlen[0] != 2) begin miscompares++; $display("FAIL single_start_len got %0d want 2", runlen[0]); end
      vectors++;
      if (start_x[0] !== 16'h00F5 || start_y[0] !== 8'h05) begin miscompares++; $display("FAIL single_operands got %h/%h want 00F5/05", start_x[0], start_y[0]); end
      vectors++;
      if (obs_cyc[0] - start_cyc[0] != 81) begin miscompares++; $display("FAIL single_latency got %0d want 81", obs_cyc[0] - start_cyc[0]); end
    end
    vectors++;
    if (stab_viol != 0) begin miscompares++; $display("FAIL single_stable got %0d operand changes want 0", stab_viol); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon();
    core_mode = 0; core_lat = 10; out_ready = 1'b1;
    push_job(16'h00F5, 8'h05);
    push_job(16'h024C, 8'h73);
    n = 0;
    while (obs_cos.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
    vectors++;
    if (obs_cos.size() != 2 || start_cyc.size() != 2) begin
      miscompares++; $display("FAIL b2b_count got %0d results want 2", obs_cos.size());
    end else begin
      vectors++;
      if (obs_cos[0] !== 16'h0094 || obs_cos[1] !== 16'hFF86) begin miscompares++; $display("FAIL b2b_order got %h,%h want 0094,FF86", obs_cos[0], obs_cos[1]); end
      vectors++;
      if (start_cyc[1] != obs_cyc[0] + 2) begin miscompares++; $display("FAIL b2b_restart got cycle %0d want %0d", start_cyc[1], obs_cyc[0] + 2); end
    end
  endtask

  task automatic test_backpressure();
    int n, held_bad;
    clear_mon();
    core_mode = 0; core_lat = 10; out_ready = 1'b0;
    push_job(16'h024C, 8'h73);
    push_job(16'h00F5, 8'h05);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    held_bad = 0;
    repeat (20) begin
      if (out_valid !== 1'b1 || out_cos !== 16'hFF86 || out_timeout !== 1'b0) held_bad++;
      @(posedge clk); #1;
    end
    vectors++;
    if (held_bad != 0) begin miscompares++; $display("FAIL bp_hold got %0d bad cycles want 0", held_bad); end
    vectors++;
    if (start_cyc.size() != 1 || fifo_count !== 3'd1) begin miscompares++; $display("FAIL bp_no_dispatch got %0d starts count %0d want 1 and 1", start_cyc.size(), fifo_count); end
    out_ready = 1'b1;
    n = 0;
    while (obs_cos.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (obs_cos.size() != 2 || start_cyc.size() != 2) begin
      miscompares++; $display("FAIL bp_drain got %0d results want 2", obs_cos.size());
    end else begin
      vectors++;
      if (obs_cos[0] !== 16'hFF86 || obs_cos[1] !== 16'h0094) begin miscompares++; $display("FAIL bp_results got %h,%h want FF86,0094", obs_cos[0], obs_cos[1]); end
      vectors++;
      if (start_cyc[1] != obs_cyc[0] + 2) begin miscompares++; $display("FAIL bp_restart got cycle %0d want %0d", start_cyc[1], obs_cyc[0] + 2); end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    int njobs, k, m;
    njobs = 16;
    clear_mon();
    core_mode = 0; core_lat = 0;
    fork
      begin
        k = 0;
        for (int i = 0; i < njobs && k < 4000; k++) begin
          in_valid = ($urandom_range(0, 2) != 0);
          in_x = 16'($urandom);
          in_y = 8'($urandom);
          @(negedge clk);
          if (in_valid && in_ready) begin exp_q.push_back(cos_ref(in_x, in_y)); i++; end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        m = 0;
        while (obs_cos.size() < njobs && m < 3000) begin
          out_ready = ($urandom_range(0, 1) != 0);
          @(posedge clk); #1; m++;
        end
        out_ready = 1'b1;
      end
    join
    vectors++;
    if (obs_cos.size() != njobs || exp_q.size() != njobs || start_cyc.size() != njobs) begin
      miscompares++; $display("FAIL rand_count got %0d results %0d accepted want %0d", obs_cos.size(), exp_q.size(), njobs);
    end else begin
      for (int i = 0; i < njobs; i++) begin
        vectors++;
        if (obs_cos[i] !== exp_q[i] || obs_to[i] !== 1'b0) begin miscompares++; $display("FAIL rand_result[%0d] got %h/%b want %h/0", i, obs_cos[i], obs_to[i], exp_q[i]); end
        if (i > 0) begin
          vectors++;
          if (start_cyc[i] < obs_cyc[i-1] + 2) begin miscompares++; $display("FAIL rand_overlap[%0d] got start %0d want >= %0d", i, start_cyc[i], obs_cyc[i-1] + 2); end
        end
      end
    end
    vectors++;
    if (stab_viol != 0) begin miscompares++; $display("FAIL rand_stable got %0d operand changes want 0", stab_viol); end
  endtask

  task automatic test_full();
    int idx, n;
    clear_mon();
    core_mode = 2; out_ready = 1'b1;
    idx = 0;
    in_valid = 1'b1; in_x = 16'h0100; in_y = 8'h00;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      in_x = 16'h0100 + 16'(idx); in_y = 8'(idx);
    end
    vectors++;
    if (idx != 5) begin miscompares++; $display("FAIL full_accepted got %0d want 5", idx); end
    vectors++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL full_state got count %0d in_ready %b busy %b want 4 0 1", fifo_count, in_ready, busy);
    end
    n = 0;
    while (idx == 5 && n < 1200) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (idx != 6 || obs_cos.size() != 1 || start_cyc.size() < 1) begin
      miscompares++; $display("FAIL full_release got %0d accepted %0d results want 6 and 1", idx, obs_cos.size());
    end else begin
      vectors++;
      if (obs_cos[0] !== 16'h0 || obs_to[0] !== 1'b1) begin miscompares++; $display("FAIL full_timeout got %h/%b want 0000/1", obs_cos[0], obs_to[0]); end
      vectors++;
      if (obs_cyc[0] - start_cyc[0] != 1023) begin miscompares++; $display("FAIL full_wdog got %0d want 1023", obs_cyc[0] - start_cyc[0]); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; core_mode = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    core_mode = 0; core_lat = 60; out_ready = 1'b1;
    push_job(16'h1111, 8'h11);
    push_job(16'h2222, 8'h22);
    push_job(16'h3333, 8'h33);
    n = 0;
    while (start_cyc.size() < 1 && n < 20) begin @(posedge clk); #1; n++; end
    repeat (15) @(posedge clk);
    #1;
    vectors++;
    if (fifo_count !== 3'd2 || busy !== 1'b1 || core_start !== 1'b0) begin
      miscompares++; $display("FAIL rmid_pre got count %0d busy %b start %b want 2 1 0", fifo_count, busy, core_start);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({fifo_count, busy, out_valid, core_start} !== 6'd0) begin
      miscompares++; $display("FAIL rmid_flush got %b want 000000", {fifo_count, busy, out_valid, core_start});
    end
    repeat (80) @(posedge clk);
    #1;
    vectors++;
    if (obs_cos.size() != 0 || start_cyc.size() != 1) begin
      miscompares++; $display("FAIL rmid_quiet got %0d results %0d starts want 0 and 1", obs_cos.size(), start_cyc.size());
    end
  endtask

  task automatic test_timeout();
    int n, s;
    t_core_ready = 1'b1; t_core_cos = 16'hBEEF; t_out_ready = 1'b1;
    t_in_valid = 1'b1; t_in_x = 16'h0ABC; t_in_y = 8'h5A;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    n = 0;
    while (!t_core_start && n < 10) begin @(posedge clk); #1; n++; end
    s = 0;
    while (!t_out_valid && s < 100) begin @(posedge clk); #1; s++; end
    vectors++;
    if (s != 50) begin miscompares++; $display("FAIL to_cycle got %0d want 50", s); end
    vectors++;
    if (t_out_cos !== 16'h0 || t_out_timeout !== 1'b1 || t_busy !== 1'b1) begin
      miscompares++; $display("FAIL to_result got %h/%b busy %b want 0000/1 busy 1", t_out_cos, t_out_timeout, t_busy);
    end
    vectors++;
    if (t_in_ready !== 1'b1) begin miscompares++; $display("FAIL to_in_ready got %b want 1", t_in_ready); end
    t_in_valid = 1'b1; t_in_x = 16'h1357; t_in_y = 8'h24;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    n = 0;
    while (!t_core_start && n < 10) begin @(posedge clk); #1; n++; end
    vectors++;
    if (t_core_start !== 1'b1 || t_core_x !== 16'h1357 || t_core_y !== 8'h24) begin
      miscompares++; $display("FAIL to_redispatch got start %b x %h y %h want 1 1357 24", t_core_start, t_core_x, t_core_y);
    end
    t_core_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    t_core_cos = 16'h1111; t_core_ready = 1'b1;
    n = 0;
    while (!t_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (t_out_valid !== 1'b1 || t_out_cos !== 16'h1111 || t_out_timeout !== 1'b0) begin
      miscompares++; $display("FAIL to_next_job got %b %h/%b want 1 1111/0", t_out_valid, t_out_cos, t_out_timeout);
    end
    @(posedge clk); #1;
    vectors++;
    if (t_busy !== 1'b0 || t_fifo_count !== 3'd0 || t_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL to_idle got busy %b count %0d valid %b want 0 0 0", t_busy, t_fifo_count, t_out_valid);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_time_limit got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    in_valid = 1'b0; in_x = 16'h0; in_y = 8'h0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_x = 16'h0; t_in_y = 8'h0; t_out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_full();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cos_job_dispatcher.md
Name: cos_job_dispatcher

Overview:
- Upstream feeder for the cos(x) accelerator core.
- Buffers (x, y) operand jobs from a valid/ready producer in a small FIFO and issues them one at a time to the core.
- Per job: drives the core's start pulse, holds operands stable, detects completion on the core's ready flag, returns the 16-bit result on a valid/ready output port.
- Includes a watchdog so a hung core cannot deadlock the pipeline.

Parameters:
- XW, 16, width of x operand
- YW, 8, width of y operand
- RW, 16, width of cos result
- DEPTH, 4, FIFO entries; power of 2, >= 2
- START_CYCLES, 2, cycles core_start is held high per job; >= 1
- TIMEOUT, 1023, max cycles from first start cycle to completion before abort; >= START_CYCLES+1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a job
- in_ready  out  1  FIFO can accept; high when fifo_count < DEPTH
- in_x  in  XW  job x operand
- in_y  in  YW  job y operand
- core_x  out  XW  operand x to core
- core_y  out  YW  operand y to core
- core_start  out  1  start pulse to core
- core_ready  in  1  core ready/done flag
- core_cos  in  RW  core result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_cos  out  RW  result (two's complement, passed through unchanged)
- out_timeout  out  1  qualifies out_valid: job aborted by watchdog
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(DEPTH)+1  entries currently buffered

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - FIFO emptied; fifo_count=0; in_ready=1.
  - FSM to IDLE.
  - core_start=0, core_x=0, core_y=0.
  - out_valid=0, out_cos=0, out_timeout=0, busy=0.
  - Watchdog and edge-detect registers cleared.
  - Reset mid-job abandons the job with no output. Core is not notified; the core shares rst.
- FIFO:
  - Push when in_valid & in_ready.
  - Pop only on the IDLE->START transition.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full is not possible (in_ready=0).
  - Pointers wrap modulo DEPTH.
  - First-word-fall-through not required: entry pushed at edge N is dispatchable at edge N+1 at earliest.
- FSM states:
  - IDLE: if fifo_count>0, pop head into core_x/core_y, go to START.
  - START: core_start=1 for exactly START_CYCLES cycles, then go to WAIT. Watchdog counter starts at 0 in first START cycle and increments every START/WAIT cycle.
  - WAIT: core_start=0. Completion = rising edge of core_ready (core_ready=1 this cycle, registered previous sample=0).
    - Edge detection is armed from the first START cycle. An edge during START is latched and honoured on entering WAIT.
    - On completion: capture core_cos into out_cos, out_timeout=0, go to OUT.
    - If watchdog reaches TIMEOUT first: out_cos=0, out_timeout=1, go to OUT.
    - Completion and timeout in the same cycle: completion wins.
  - OUT: out_valid=1, out_cos/out_timeout stable. On out_ready go to IDLE; out_valid drops next cycle. No new dispatch in the handshake cycle.
- core_x/core_y are held constant from dispatch until return to IDLE. In IDLE they keep their last values (not zeroed).
- busy=1 in START, WAIT, OUT.
- A core_ready level held high (idle core) never counts as completion; only a 0->1 transition does.
- Throughput: one job in flight. Minimum job cost = 1 (IDLE) + START_CYCLES + core latency + 1 (OUT).

Test Plan:
- Single job: push x=0x00F5 y=0x05; core model drops ready during start, raises it 80 cycles later with cos=0x0094.
  -> core_start high exactly 2 cycles; core_x/core_y stable throughout; out_valid with out_cos=0x0094, out_timeout=0.
- Back-to-back: push (0x00F5,0x05) then (0x024C,0x73) on consecutive cycles; model returns 0x0094 then 0xFF86; out_ready tied high.
  -> results in order 0x0094, 0xFF86; second core_start begins one cycle after first OUT handshake plus IDLE cycle.
- Full FIFO: core_ready held low, push 7 jobs continuously.
  -> first job dispatched; next 4 accepted (fifo_count=4); in_ready=0 from then on; jobs 6-7 stall until a pop.
- Timeout: TIMEOUT=50, core_ready stays at 1 (no edge).
  -> out_valid on cycle 50 after first START cycle with out_cos=0x0000, out_timeout=1; next job then dispatched normally.
- Backpressure: out_ready=0 for 20 cycles after result 0xFF86.
  -> out_valid and out_cos=0xFF86 held all 20 cycles; no new core_start until handshake.
- Reset mid-WAIT with 2 jobs queued.
  -> next cycle: fifo_count=0, busy=0, out_valid=0, core_start=0; later core_ready edge produces no output.
